// File: rtl/shift_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : shift_receiver
//  Purpose  : Serial-to-parallel receiver for an MSB-first frame of WIDTH bits
//             with a one-deep valid/ack output holding register and a sticky
//             overrun flag.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock, all state on rising edge
//    rst_n      in   asynchronous active-low reset
//    serial_in  in   serial data, MSB first
//    start      in   marks the first (MSB) bit of a frame
//    en         in   sample enable; low stalls the receiver
//    data_ack   in   consumer acknowledge of data_out
//    clr_ovr    in   synchronous clear of overrun
//    data_out   out  last completed word (WIDTH bits)
//    data_valid out  data_out holds an unacknowledged word
//    busy       out  frame in progress
//    bit_cnt    out  bits received in the current frame
//    overrun    out  sticky: a completed word was dropped
// ============================================================================
module shift_receiver #(
  // Word length; bit_cnt is 4 bits, so WIDTH must lie in 3..16.
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             start,
  input  logic             en,
  input  logic             data_ack,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [3:0]       bit_cnt,
  output logic             overrun
);

  localparam logic [3:0] C_LAST_CNT = 4'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  // Only the low WIDTH-1 bits are ever needed: the bit arriving on the last
  // edge is taken straight from serial_in when the word is formed.
  logic [WIDTH-2:0]   r_shift;
  logic [WIDTH-2:0]   w_shift_nxt;
  logic [3:0]         r_bit_cnt;
  logic [3:0]         w_bit_cnt_nxt;
  logic               w_word_done;
  logic [WIDTH-1:0]   w_word;

  assign w_word = {r_shift, serial_in};

  // State / shift register / counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_word_done   = 1'b0;
    if (en) begin
      if (start) begin
        // Start always (re)opens a frame; in RECV the partial word is dropped.
        w_state_nxt   = RECV;
        w_shift_nxt   = {{(WIDTH-2){1'b0}}, serial_in};
        w_bit_cnt_nxt = 4'd1;
      end else if (r_state == RECV) begin
        if (r_bit_cnt == C_LAST_CNT) begin
          w_word_done   = 1'b1;
          w_state_nxt   = IDLE;
          w_shift_nxt   = '0;
          w_bit_cnt_nxt = 4'd0;
        end else begin
          w_shift_nxt   = {r_shift[WIDTH-3:0], serial_in};
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
        end
      end
    end
  end

  // Output holding register and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (w_word_done && (!data_valid || data_ack)) begin
        // Completing word replaces an acknowledged one without a gap.
        data_out   <= w_word;
        data_valid <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end

      // Set has priority over clear.
      if (w_word_done && data_valid && !data_ack) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy    = (r_state == RECV);
  assign bit_cnt = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_shift_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_receiver
//  Purpose  : Self-checking bench for shift_receiver: directed scenarios plus
//             randomized traffic against a behavioural frame model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_receiver;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             serial_in;
  logic             start;
  logic             en;
  logic             data_ack;
  logic             clr_ovr;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic [3:0]       bit_cnt;
  logic             overrun;

  int total;
  int bad;

  // Behavioural model: frame progress as a bit count plus an arithmetic
  // accumulator, and the consumer-side view of the output register.
  bit      m_in_frame;
  int      m_nbits;
  longint  m_acc;
  bit      m_valid;
  longint  m_dout;
  bit      m_ovr;

  shift_receiver #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .start      (start),
    .en         (en),
    .data_ack   (data_ack),
    .clr_ovr    (clr_ovr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_nbits = 0; m_acc = 0;
    m_valid = 0; m_dout = 0; m_ovr = 0;
  endtask

  task automatic model_edge(input bit e, input bit s, input bit d, input bit a, input bit c);
    bit done;
    bit set_ovr;
    done = 0;
    set_ovr = 0;
    if (e && s) begin
      m_in_frame = 1;
      m_nbits    = 1;
      m_acc      = d;
    end else if (e && m_in_frame) begin
      m_acc   = (m_acc * 2 + d) % (64'd1 << WIDTH);
      m_nbits = m_nbits + 1;
      if (m_nbits == WIDTH) begin
        m_in_frame = 0;
        m_nbits    = 0;
        if (!m_valid || a) begin
          m_dout  = m_acc;
          m_valid = 1;
          done    = 1;
        end else begin
          set_ovr = 1;
        end
      end
    end
    if (a && !done) m_valid = 0;
    if (set_ovr) m_ovr = 1;
    else if (c)  m_ovr = 0;
  endtask

  task automatic compare_all();
    check("data_out",   32'(data_out),   32'(m_dout));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("busy",       32'(busy),       32'(m_in_frame));
    check("bit_cnt",    32'(bit_cnt),    32'(m_nbits));
    check("overrun",    32'(overrun),    32'(m_ovr));
  endtask

  // One clock: drive inputs, take the edge, update model, compare after it.
  task automatic step(input bit e, input bit s, input bit d, input bit a, input bit c);
    en = e; start = s; serial_in = d; data_ack = a; clr_ovr = c;
    @(posedge clk);
    model_edge(e, s, d, a, c);
    #1;
    compare_all();
  endtask

  // Send bits [hi:lo] of word MSB first; start on bit WIDTH-1.
  task automatic send_bits(input logic [WIDTH-1:0] word, input int hi, input int lo, input bit ack_last);
    for (int i = hi; i >= lo; i--) begin
      step(1'b1, i == WIDTH-1, word[i], (i == lo) ? ack_last : 1'b0, 1'b0);
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] word, input bit ack_last);
    send_bits(word, WIDTH-1, 0, ack_last);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"},  32'(data_out),   32'h0);
    check({tag, "_valid"}, 32'(data_valid), 32'h0);
    check({tag, "_busy"},  32'(busy),       32'h0);
    check({tag, "_cnt"},   32'(bit_cnt),    32'h0);
    check({tag, "_ovr"},   32'(overrun),    32'h0);
  endtask

  initial begin
    logic [WIDTH-1:0] rw;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en = 0; start = 0; serial_in = 0; data_ack = 0; clr_ovr = 0;
    model_reset();

    // Reset state
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // Data without a start is ignored
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("nostart_busy", 32'(busy), 32'h0);

    // Basic frame
    send_word(16'h0101, 1'b0);
    check("basic_dout",  32'(data_out),   32'h0101);
    check("basic_valid", 32'(data_valid), 32'h1);
    check("basic_busy",  32'(busy),       32'h0);
    check("basic_cnt",   32'(bit_cnt),    32'h0);

    // Back-to-back with ack at completion edge
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ack_clears", 32'(data_valid), 32'h0);
    send_word(16'h1111, 1'b0);
    send_word(16'hAAAA, 1'b1);
    check("b2b_dout",  32'(data_out),   32'hAAAA);
    check("b2b_valid", 32'(data_valid), 32'h1);
    check("b2b_ovr",   32'(overrun),    32'h0);

    // Overrun
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(16'hC000, 1'b0);
    send_word(16'h8000, 1'b0);
    check("ovr_dout", 32'(data_out), 32'hC000);
    check("ovr_set",  32'(overrun),  32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr_clr",  32'(overrun),  32'h0);

    // Restart after 7 bits
    send_bits(16'hE000, WIDTH-1, WIDTH-7, 1'b0);
    check("restart_cnt7", 32'(bit_cnt), 32'h7);
    send_word(16'h001F, 1'b0);
    check("restart_dout", 32'(data_out), 32'h001F);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_novalid", 32'(data_valid), 32'h0);

    // Stall at bit 8
    send_bits(16'hA5A5, WIDTH-1, 8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, i[0], 1'b0, 1'b0);
      check("stall_cnt", 32'(bit_cnt), 32'h8);
    end
    send_bits(16'hA5A5, 7, 0, 1'b0);
    check("stall_dout", 32'(data_out), 32'hA5A5);

    // Reset mid-frame (asserted between edges)
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(16'h3C3C, 1'b0);
    send_bits(16'h5A5A, WIDTH-1, WIDTH-10, 1'b0);
    #3;
    rst_n = 1'b0;
    en = 0; start = 0; serial_in = 0; data_ack = 0; clr_ovr = 0;
    #1;
    check_all_zero("rstmid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(16'h5A5A, 1'b0);
    check("after_rst_dout", 32'(data_out), 32'h5A5A);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit e;
      e = ($urandom_range(3) != 0);
      step(e, e && ($urandom_range(19) == 0), 1'($urandom),
           e && ($urandom_range(3) == 0), e && ($urandom_range(15) == 0));
    end
    // Random whole frames with random acks
    for (int i = 0; i < 40; i++) begin
      rw = 16'($urandom);
      send_word(rw, 1'($urandom));
      step(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_receiver.md
SHIFT_RECEIVER -- requirements
Module: shift_receiver

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 16, setting the received word length in bits.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 Port serial_in SHALL be an input, 1 bit wide: the serial data stream from the parallel-load shift register's shift_out, MSB first.
REQ-005 Port start SHALL be an input, 1 bit wide: high in the cycle serial_in carries bit WIDTH-1 (first bit) of a frame.
REQ-006 Port en SHALL be an input, 1 bit wide: sample enable; while low, no bit is taken and all state holds.
REQ-007 Port data_ack SHALL be an input, 1 bit wide: consumer acknowledge of the word on data_out.
REQ-008 Port data_out SHALL be an output, WIDTH bits wide: the last completed word.
REQ-009 Port data_valid SHALL be an output, 1 bit wide: data_out holds an unacknowledged word.
REQ-010 Port busy SHALL be an output, 1 bit wide: a frame is in progress.
REQ-011 Port bit_cnt SHALL be an output, 4 bits wide: count of bits received in the current frame (0..WIDTH-1).
REQ-012 Port overrun SHALL be an output, 1 bit wide: sticky flag, set when a word was lost.
REQ-013 Port clr_ovr SHALL be an input, 1 bit wide: a synchronous clear of overrun.

Function
REQ-014 The FSM SHALL have two states: IDLE and RECV.
REQ-015 In IDLE, on an edge with en=1 and start=1, the block SHALL load serial_in into shift-register bit 0, set bit_cnt=1, and go to RECV.
REQ-016 In IDLE, the block SHALL ignore serial_in when start=0.
REQ-017 In RECV, on each edge with en=1 and start=0, the block SHALL shift left, insert serial_in at bit 0, and increment bit_cnt.
REQ-018 In RECV, an edge with en=1 and start=1 SHALL abort the partial frame without any output and restart per REQ-015, with bit_cnt=1.
REQ-019 When the WIDTH-th bit is sampled, the block SHALL form the word as {shift[WIDTH-2:0], serial_in}, set bit_cnt=0, and return to IDLE.
REQ-020 At that same edge, if data_valid=0 or data_ack=1, the block SHALL write the word to data_out and set data_valid=1.
REQ-021 Otherwise (data_valid=1 and data_ack=0), the block SHALL discard the word, leave data_out unchanged, and set overrun=1.
REQ-022 Latency: data_valid SHALL be visible in the cycle after the edge on which the last bit is sampled.
REQ-023 Because en=0 stalls, a frame SHALL take WIDTH enabled edges, not WIDTH clocks.
REQ-024 data_valid SHALL clear on an edge with data_ack=1, unless a word completes at that same edge, in which case it stays 1 with the new data.
REQ-025 data_ack while data_valid=0 SHALL have no effect.
REQ-026 data_out SHALL remain stable while data_valid=1.
REQ-027 overrun SHALL clear only on clr_ovr=1; if set and clear coincide, set SHALL win.
REQ-028 busy SHALL be 1 exactly when state=RECV.
REQ-029 A frame that stalls indefinitely with en=0 SHALL remain in RECV; there SHALL be no timeout.

Reset
REQ-030 While rst_n=0, regardless of clk, the block SHALL force state=IDLE, the shift register=0, data_out=0, data_valid=0, busy=0, bit_cnt=0 and overrun=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial word.
REQ-032 After release, the block SHALL need a new start before it accepts any data.

Verification
REQ-033 Bench scenario, basic frame: start with en=1, then stream 16'h0101 MSB first. Expected: data_out=16'h0101 and data_valid=1 one cycle after the 16th edge; busy=0 and bit_cnt=0.
REQ-034 Bench scenario, back-to-back words: receive 16'h1111, ack it at the completion edge of the next frame 16'hAAAA. Expected: data_valid stays 1 with data_out=16'hAAAA, and overrun=0.
REQ-035 Bench scenario, overrun: receive 16'hC000 with no ack, then receive 16'h8000. Expected: data_out stays 16'hC000 and overrun=1; clr_ovr then clears it.
REQ-036 Bench scenario, restart: assert start after 7 bits of 16'hE000, then send 16'h001F. Expected: data_out=16'h001F, and no word is output for the aborted frame.
REQ-037 Bench scenario, stall: hold en=0 for 5 cycles at bit 8 of 16'hA5A5. Expected: bit_cnt holds at 8, and the result is data_out=16'hA5A5.
REQ-038 Bench scenario, reset mid-frame: pull rst_n low at bit 10. Expected: all outputs read 0 immediately, without waiting for a clk edge, and the next full frame is received correctly.
